// File: rtl/control_unit_pkg.sv
// Shared constants for the instruction-sequencing control unit: opcodes,
// FSM state encodings and program-counter operation codes.
package control_unit_pkg;

  localparam logic [3:0] OP_LOAD  = 4'h8;
  localparam logic [3:0] OP_WRITE = 4'h9;
  localparam logic [3:0] OP_JMP   = 4'hA;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_REGREAD   = 3'd3,
    ST_EXECUTE   = 3'd4,
    ST_MEMORY    = 3'd5,
    ST_WRITEBACK = 3'd6,
    ST_FAULT     = 3'd7
  } state_e;

  localparam logic [1:0] PC_HOLD = 2'd0;
  localparam logic [1:0] PC_INC  = 2'd1;
  localparam logic [1:0] PC_LOAD = 2'd2;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/control_unit_wait_timer.sv
// Counts memory wait cycles and flags the cycle in which the count would
// reach TIMEOUT while the request is still outstanding.
module wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (count_i)
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  // Fires on the wait cycle that would bring the count up to TIMEOUT.
  assign expired_o = count_i && (cnt_q == LIMIT);

endmodule

// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer: fetch, decode, register read, execute,
// optional memory access and writeback, with halt handling and a memory
// wait timeout that parks the unit in FAULT until reset.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       I_clk,
  input  logic       I_reset,
  input  logic [3:0] I_opcode,
  input  logic       I_branch_taken,
  input  logic       I_mem_ready,
  input  logic       I_halt,
  output logic       O_en_fetch,
  output logic       O_en_decode,
  output logic       O_en_regread,
  output logic       O_en_alu,
  output logic       O_en_regwrite,
  output logic       O_mem_req,
  output logic       O_mem_we,
  output logic [1:0] O_pc_op,
  output logic [2:0] O_state,
  output logic       O_halted,
  output logic       O_fault
);

  state_e     state_q, state_d;
  logic [3:0] opcode_q, opcode_d;
  logic       wait_state;
  logic       timer_clear;
  logic       timer_count;
  logic       timer_expired;
  state_e     end_of_instr;

  assign wait_state  = (state_q == ST_FETCH) || (state_q == ST_MEMORY);
  assign timer_count = wait_state && !I_mem_ready;
  // Any completed request also clears, so a WRITE ending straight into FETCH starts from zero.
  assign timer_clear = !wait_state || I_mem_ready;

  wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk_i    (I_clk),
    .reset_i  (I_reset),
    .clear_i  (timer_clear),
    .count_i  (timer_count),
    .expired_o(timer_expired)
  );

  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    end_of_instr = I_halt ? ST_IDLE : ST_FETCH;
    if (state_q == ST_REGREAD)
      opcode_d = I_opcode;
    case (state_q)
      ST_IDLE:      if (!I_halt) state_d = ST_FETCH;
      ST_FETCH: begin
        if (I_mem_ready)        state_d = ST_DECODE;
        else if (timer_expired) state_d = ST_FAULT;
      end
      ST_DECODE:    state_d = ST_REGREAD;
      ST_REGREAD:   state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        if (is_mem_op(opcode_q))   state_d = ST_MEMORY;
        else if (opcode_q == OP_JMP) state_d = end_of_instr;
        else                       state_d = ST_WRITEBACK;
      end
      ST_MEMORY: begin
        if (I_mem_ready)
          state_d = (opcode_q == OP_LOAD) ? ST_WRITEBACK : end_of_instr;
        else if (timer_expired)
          state_d = ST_FAULT;
      end
      ST_WRITEBACK: state_d = end_of_instr;
      default:      state_d = ST_FAULT;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_q  <= ST_FETCH;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  always_comb begin
    O_en_fetch    = 1'b0;
    O_en_decode   = 1'b0;
    O_en_regread  = 1'b0;
    O_en_alu      = 1'b0;
    O_en_regwrite = 1'b0;
    O_mem_req     = 1'b0;
    O_mem_we      = 1'b0;
    O_pc_op       = PC_HOLD;
    O_state       = state_q;
    O_halted      = 1'b0;
    O_fault       = 1'b0;
    case (state_q)
      ST_IDLE:    O_halted = 1'b1;
      ST_FETCH: begin
        O_en_fetch = 1'b1;
        O_mem_req  = 1'b1;
      end
      ST_DECODE:  O_en_decode = 1'b1;
      ST_REGREAD: O_en_regread = 1'b1;
      ST_EXECUTE: begin
        O_en_alu = 1'b1;
        if (opcode_q == OP_JMP)
          O_pc_op = I_branch_taken ? PC_LOAD : PC_INC;
      end
      ST_MEMORY: begin
        O_mem_req = 1'b1;
        O_mem_we  = (opcode_q == OP_WRITE);
        // A WRITE retires in the cycle its request completes.
        if ((opcode_q == OP_WRITE) && I_mem_ready)
          O_pc_op = PC_INC;
      end
      ST_WRITEBACK: begin
        O_en_regwrite = 1'b1;
        O_pc_op       = PC_INC;
      end
      default:    O_fault = 1'b1;
    endcase
    // An instruction in flight when reset arrives is abandoned: show the
    // post-reset FETCH pattern and never emit its PC update.
    if (I_reset) begin
      O_en_fetch    = 1'b1;
      O_en_decode   = 1'b0;
      O_en_regread  = 1'b0;
      O_en_alu      = 1'b0;
      O_en_regwrite = 1'b0;
      O_mem_req     = 1'b1;
      O_mem_we      = 1'b0;
      O_pc_op       = PC_HOLD;
      O_state       = ST_FETCH;
      O_halted      = 1'b0;
      O_fault       = 1'b0;
    end
  end

endmodule
